// File: rtl/vga_timing_ctrl.sv
// Raster timing source: 640x480@60 VGA counters, sync/blank decode, and
// frame-stable shadows of game state and tile matrix loaded at vblank start.
module vga_timing_ctrl #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state_in,
  input  logic [11:0] matrix_in  [3:0][3:0],
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        sync_n,
  output logic        vga_clk,
  output logic [2:0]  state_out,
  output logic [11:0] matrix_out [3:0][3:0],
  output logic        vblank_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W   = 10'(V_VIS);
  localparam logic [9:0] V_VIS_END = 10'(V_VIS - 1);
  localparam logic [9:0] HS_BEG    = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG    = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VIS + V_FP + V_SYNC);

  logic        tog_q, tog_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [2:0]  state_q, state_d;
  logic [11:0] matrix_q [3:0][3:0];
  logic [11:0] matrix_d [3:0][3:0];
  logic        vblank_q, vblank_d;
  logic        load;

  always_comb begin
    tog_d    = ~tog_q;
    x_d      = x_q;
    y_d      = y_q;
    load     = 1'b0;
    state_d  = state_q;
    matrix_d = matrix_q;
    if (tog_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        // Last visible line wrapping into the first blanking line.
        load = (y_q == V_VIS_END);
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    if (load) begin
      state_d  = state_in;
      matrix_d = matrix_in;
    end
    vblank_d = load;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tog_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      state_q  <= '0;
      matrix_q <= '{default: '0};
      vblank_q <= 1'b0;
    end else begin
      tog_q    <= tog_d;
      x_q      <= x_d;
      y_q      <= y_d;
      state_q  <= state_d;
      matrix_q <= matrix_d;
      vblank_q <= vblank_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign vga_clk      = tog_q;
  assign sync_n       = 1'b0;
  assign hsync        = !((x_q >= HS_BEG) && (x_q < HS_END));
  assign vsync        = !((y_q >= VS_BEG) && (y_q < VS_END));
  assign blank_n      = (x_q < H_VIS_W) && (y_q < V_VIS_W);
  assign state_out    = state_q;
  assign matrix_out   = matrix_q;
  assign vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl using a shrunken raster (25x17, 850 clk
// frame): hsync x=18..21, vsync y=12..13, visible 16x10, load edge (24,9)->(0,10).
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state_in;
  logic [11:0] matrix_in  [3:0][3:0];
  logic [9:0]  x, y;
  logic        hsync, vsync, blank_n, sync_n, vga_clk, vblank_start;
  logic [2:0]  state_out;
  logic [11:0] matrix_out [3:0][3:0];

  int n_chk  = 0;
  int n_pass = 0;

  vga_timing_ctrl #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk(clk), .rst(rst), .state_in(state_in), .matrix_in(matrix_in),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .sync_n(sync_n), .vga_clk(vga_clk), .state_out(state_out),
    .matrix_out(matrix_out), .vblank_start(vblank_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_to(input int tx, input int ty);
    int n = 0;
    while (!(int'(x) == tx && int'(y) == ty) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk("adv_timeout", n, 0);
  endtask

  initial begin
    int cnt_hs, cnt_vs, cnt_bn, cnt_bad;
    rst      = 1'b0;
    state_in = 3'b000;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        matrix_in[i][j] = 12'h000;

    // Reset values
    repeat (3) tick();
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_blank_n", blank_n, 1);
    chk("rst_vga_clk", vga_clk, 0);
    chk("rst_sync_n", sync_n, 0);
    chk("rst_state_out", state_out, 0);
    chk("rst_vblank", vblank_start, 0);

    rst = 1'b1;
    tick();
    chk("rel1_x", x, 0);
    chk("rel1_vga_clk", vga_clk, 1);
    tick();
    chk("rel2_x", x, 1);
    tick();
    tick();
    chk("rel4_x", x, 2);

    // Line timing
    adv_to(15, 0);
    chk("x15_blank_n", blank_n, 1);
    adv_to(16, 0);
    chk("x16_blank_n", blank_n, 0);
    adv_to(17, 0);
    chk("x17_hsync", hsync, 1);
    adv_to(18, 0);
    chk("x18_hsync", hsync, 0);
    adv_to(21, 0);
    chk("x21_hsync", hsync, 0);
    adv_to(22, 0);
    chk("x22_hsync", hsync, 1);
    adv_to(0, 1);
    cnt_hs = 0;
    for (int c = 0; c < 50; c++) begin
      if (!hsync) cnt_hs++;
      tick();
    end
    chk("line_hs_clk", cnt_hs, 8);
    chk("line_x", x, 0);
    chk("line_y", y, 2);

    // Frame timing
    cnt_vs = 0; cnt_bn = 0; cnt_bad = 0;
    for (int c = 0; c < 850; c++) begin
      if (!vsync) begin
        cnt_vs++;
        if (y != 10'd12 && y != 10'd13) cnt_bad++;
      end
      if (blank_n) begin
        cnt_bn++;
        if (y >= 10'd10) cnt_bad++;
      end
      tick();
    end
    chk("frame_vs_clk", cnt_vs, 100);
    chk("frame_bn_clk", cnt_bn, 320);
    chk("frame_bad", cnt_bad, 0);
    chk("frame_x", x, 0);
    chk("frame_y", y, 2);
    adv_to(24, 16);
    tick();
    chk("wrap_pre_x", x, 24);
    tick();
    chk("wrap_x", x, 0);
    chk("wrap_y", y, 0);

    // Shadow capture
    adv_to(0, 3);
    state_in = 3'b010;
    matrix_in[0][0] = 12'd2048;
    adv_to(0, 6);
    state_in = 3'b011;
    matrix_in[0][0] = 12'd1024;
    matrix_in[3][3] = 12'd4;
    chk("shd_hold_state", state_out, 0);
    chk("shd_hold_m00", matrix_out[0][0], 0);
    adv_to(24, 9);
    tick();
    chk("shd_pre_state", state_out, 0);
    chk("shd_pre_vblank", vblank_start, 0);
    tick();
    chk("shd_load_y", y, 10);
    chk("shd_load_state", state_out, 3);
    chk("shd_load_m00", matrix_out[0][0], 1024);
    chk("shd_load_m33", matrix_out[3][3], 4);
    chk("shd_vblank", vblank_start, 1);
    state_in = 3'b111;
    matrix_in[0][0] = 12'd8;
    tick();
    chk("shd_vblank_off", vblank_start, 0);
    repeat (20) tick();
    chk("shd_keep_state", state_out, 3);
    chk("shd_keep_m00", matrix_out[0][0], 1024);

    // Same-cycle change
    adv_to(24, 9);
    tick();
    state_in = 3'b101;
    tick();
    chk("same_state", state_out, 5);
    chk("same_m00", matrix_out[0][0], 8);

    // Reset mid-frame
    adv_to(20, 12);
    chk("mid_vsync_lo", vsync, 0);
    chk("mid_hsync_lo", hsync, 0);
    rst = 1'b0;
    tick();
    chk("mid_x", x, 0);
    chk("mid_y", y, 0);
    chk("mid_vsync", vsync, 1);
    chk("mid_state", state_out, 0);
    chk("mid_m00", matrix_out[0][0], 0);
    chk("mid_vga_clk", vga_clk, 0);
    rst = 1'b1;
    state_in = 3'b110;
    adv_to(24, 9);
    tick();
    chk("mid_pre_state", state_out, 0);
    tick();
    chk("mid_reload_y", y, 10);
    chk("mid_reload_state", state_out, 6);
    chk("mid_reload_vblank", vblank_start, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster timing source for the 2048 game display. Generates 640x480@60 Hz VGA timing from the 50 MHz system clock and drives the pixel coordinates `x`/`y` consumed by the pixel colour generator. It also shadows the game `state` and tile `matrix` so that they change only at the start of vertical blanking, which prevents tearing during a visible frame. It sits between the game FSM/board logic and the pixel colour generator, and drives the DAC sync/blank pins.

## Interface
Parameters:
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk` in 1: 50 MHz system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `state_in` in 3: live game state from the game FSM.
- `matrix_in` in [11:0] [3:0][3:0]: live tile values.
- `x` out 10: horizontal pixel counter, 0..799.
- `y` out 10: vertical line counter, 0..524.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `blank_n` out 1: high while (x,y) is inside the visible region.
- `sync_n` out 1: tied to 0, because sync-on-green is not used.
- `vga_clk` out 1: 25 MHz pixel clock for the DAC.
- `state_out` out 3: frame-stable copy of `state_in`.
- `matrix_out` out [11:0] [3:0][3:0]: frame-stable copy of `matrix_in`.
- `vblank_start` out 1: one-`clk` pulse at the start of vertical blanking.

## Operation
- **Pixel enable.**
  - Register `tog` inverts on every `clk` edge.
  - `vga_clk` = `tog`.
  - Counters advance only on edges where `tog`==1, i.e. every second `clk`.
- **Horizontal counter.** `x` counts 0..H_TOT-1 (H_TOT = sum of the H params = 800), then wraps to 0.
- **Vertical counter.**
  - `y` increments on each `x` wrap.
  - `y` counts 0..V_TOT-1 (V_TOT = sum of the V params = 525), then wraps to 0.
  - The wrap at (799,524) takes both counters to (0,0) on the same edge.
- **Decoded outputs.** These are combinational from the `x`/`y` registers, so they have zero latency relative to the coordinates.
  - `hsync` = 0 iff H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC, i.e. x in 656..751.
  - `vsync` = 0 iff V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC, i.e. y in 490..491.
  - `blank_n` = (x < H_VIS) && (y < V_VIS).
- **Frame shadow registers.**
  - Load trigger: the advancing edge on which (x,y) goes from (799,479) to (0,480).
  - On that edge `state_out` <= `state_in` and `matrix_out` <= `matrix_in`, all 16 entries at once.
  - At all other times both hold their value, whatever `*_in` does.
- **`vblank_start`.** Registered; high for exactly the one `clk` cycle following the shadow-load edge.
- **Reset** (`rst`==0 at a clock edge):
  - `tog`=0, `x`=0, `y`=0.
  - `state_out`=3'b000, `matrix_out` all 12'h000.
  - `vblank_start`=0.
  - Resulting outputs: `hsync`=1, `vsync`=1, `blank_n`=1, `vga_clk`=0, `sync_n`=0.
  - Reset asserted mid-line or mid-frame has the same effect: immediate restart at (0,0) on that edge, with no partial-line completion.

## Timing
- After `rst` deasserts, the first edge sets `tog`=1 and the second edge moves `x` from 0 to 1.
- Steady state: `x` increments every 2 `clk`.
- Line length: 1600 `clk`. Frame length: 840 000 `clk` (≈59.52 Hz).
- `hsync` low for 192 `clk` per line; `vsync` low for 3200 `clk` per frame.
- A change on `state_in`/`matrix_in` reaches `*_out` at the next vblank load edge:
  - minimum 1 `clk` if the change lands in the cycle immediately before the load edge;
  - maximum 1 frame.
- A change on `*_in` in the same cycle as the load edge is captured (the value sampled at that edge).

## Test plan
- **Reset values.** Hold `rst`=0 for 3 cycles, then release.
  - During reset: `x`=`y`=0, `hsync`=`vsync`=`blank_n`=1, `vga_clk`=0.
  - After release: `x`=1 exactly 2 `clk` later and `x`=2 after 4 `clk`.
- **Line timing.** Run one line.
  - `blank_n` falls at x=640.
  - `hsync` is low for x=656..751 (192 `clk`).
  - `x` wraps from 799 to 0 and `y` increments, 1600 `clk` per line.
- **Frame timing.** Run a full frame.
  - `vsync` low only on y=490,491.
  - (799,524) goes to (0,0) on one edge.
  - The frame is 840 000 `clk`; `blank_n`=0 for all y>=480.
- **Shadow capture.**
  - Stimulus: set `state_in`=3'b010 and matrix[0][0]=12'd2048 mid-frame (y=100), then change them again at y=300.
  - `*_out` stay 0 until the (0,480) edge, then show the y=300 values.
  - `vblank_start` is high for exactly 1 `clk`.
- **Same-cycle change.**
  - Stimulus: change `state_in` to 3'b101 in the cycle sampled by the load edge.
  - Required: `state_out`=3'b101 immediately after that edge.
- **Reset mid-frame.**
  - Stimulus: assert `rst` at (x=700,y=490) while `vsync`=0.
  - Next edge: `x`=`y`=0, `vsync`=1, `*_out` cleared.
  - Timing resumes correctly and the shadow next loads at (0,480).
